csr_timer_unit: RTL and testbench

- Parametrised multi-channel timer and interrupt-source block for the LoongArch CSR space.
- Provides NUM_TIMERS independent TCFG/TVAL/TICLR channels, a shared programmable prescaler, and a 64-bit free-running stable counter.
- Sits beside the CSR register file: it decodes its own CSR addresses on the shared read/write port.
- Per-channel pending bits feed ESTAT.IS; timer_int_any feeds IS[11].

---
 rtl/csr_timer_unit_pkg.sv | 19 +
 rtl/csr_timer_unit_if.sv | 12 +
 rtl/csr_timer_chan.sv | 46 ++++
 rtl/csr_timer_unit.sv | 65 ++++++
 tb/tb_csr_timer_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/csr_timer_unit_pkg.sv
// csr_timer_unit_pkg: shared CSR field positions, address map constants and helpers for the timer unit
package csr_timer_unit_pkg;
  localparam int TCFG_EN     = 0;
  localparam int TCFG_PERIOD = 1;
  localparam int TCFG_INITV  = 2;
  localparam int TICLR_CLR   = 0;
  localparam logic [13:0] DEF_TCFG_BASE = 14'h41;
  localparam logic [13:0] DEF_PSC_ADDR  = 14'h48;
  localparam int CH_STRIDE = 4;
  localparam int OFF_TCFG  = 0;
  localparam int OFF_TVAL  = 1;
  localparam int OFF_TICLR = 3;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] mask, input logic [31:0] data);
    return (mask & data) | (~mask & old);
  endfunction
  function automatic logic [13:0] chan_addr(input logic [13:0] base, input int i, input int off);
    return base + 14'(CH_STRIDE * i + off);
  endfunction
endpackage

// File: rtl/csr_timer_unit_if.sv
// csr_timer_unit_if: shared CSR read/write port between the register file side and the timer unit
interface csr_timer_unit_if;
  logic [13:0] raddr;
  logic [31:0] rdata;
  logic        rhit;
  logic        we;
  logic [13:0] waddr;
  logic [31:0] wmask;
  logic [31:0] wdata;
  modport master(output raddr, we, waddr, wmask, wdata, input rdata, rhit);
  modport slave(input raddr, we, waddr, wmask, wdata, output rdata, rhit);
endinterface

// File: rtl/csr_timer_chan.sv
// csr_timer_chan: one TCFG/TVAL/TICLR timer channel with its down-counter and pending bit
module csr_timer_chan
  import csr_timer_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tcfg_we,
  input  logic        ticlr_we,
  input  logic        tick,
  input  logic [31:0] wmask,
  input  logic [31:0] wdata,
  output logic [31:0] tcfg,
  output logic [31:0] tval,
  output logic        pending
);
  logic             en, periodic;
  logic [CNT_W-3:0] initval;
  logic [CNT_W-1:0] cnt, cfg_new;
  logic             count, fire, clr;
  assign tcfg    = 32'({initval, periodic, en});
  assign tval    = 32'(cnt);
  assign cfg_new = CNT_W'(merge(tcfg, wmask, wdata));
  // any TCFG write owns the counter for that cycle, so a pending count is dropped
  assign count   = en && tick && !(&cnt) && !tcfg_we;
  assign fire    = count && cnt == '0;
  assign clr     = ticlr_we && wmask[TICLR_CLR] && wdata[TICLR_CLR];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      initval  <= '0;
      cnt      <= '1;
      pending  <= 1'b0;
    end else begin
      if (tcfg_we) begin
        en       <= cfg_new[TCFG_EN];
        periodic <= cfg_new[TCFG_PERIOD];
        initval  <= cfg_new[CNT_W-1:TCFG_INITV];
        if (cfg_new[TCFG_EN]) cnt <= {cfg_new[CNT_W-1:TCFG_INITV], 2'b00};
      end else if (count)
        cnt <= fire ? (periodic ? {initval, 2'b00} : '1) : cnt - CNT_W'(1);
      pending <= fire || (pending && !clr);
    end
endmodule

// File: rtl/csr_timer_unit.sv
// csr_timer_unit: multi-channel CSR timer block with shared prescaler, stable counter and CSR decode
module csr_timer_unit
  import csr_timer_unit_pkg::*;
#(
  parameter int          NUM_TIMERS = 1,
  parameter int          CNT_W      = 32,
  parameter logic [13:0] TCFG_BASE  = DEF_TCFG_BASE,
  parameter logic [13:0] PSC_ADDR   = DEF_PSC_ADDR,
  parameter int          PSC_W      = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  csr_timer_unit_if.slave       csr,
  output logic [NUM_TIMERS-1:0] timer_int,
  output logic                  timer_int_any,
  output logic [63:0]           stable_cnt
);
  logic [PSC_W-1:0] psc_val, psc_cnt;
  logic             psc_we, tick;
  logic [31:0]      tcfg [NUM_TIMERS];
  logic [31:0]      tval [NUM_TIMERS];
  logic [31:0]      rdata;
  logic             rhit;
  assign psc_we = csr.we && csr.waddr == PSC_ADDR;
  // a prescaler write restarts the phase, so it never ticks in that cycle
  assign tick   = psc_cnt == psc_val && !psc_we;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      psc_val    <= '0;
      psc_cnt    <= '0;
      stable_cnt <= '0;
    end else begin
      if (psc_we) psc_val <= PSC_W'(merge(32'(psc_val), csr.wmask, csr.wdata));
      psc_cnt    <= (psc_we || tick) ? '0 : psc_cnt + PSC_W'(1);
      stable_cnt <= stable_cnt + 64'd1;
    end
  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    csr_timer_chan #(.CNT_W(CNT_W)) u_chan (
      .clk      (clk),
      .resetn   (resetn),
      .tcfg_we  (csr.we && csr.waddr == chan_addr(TCFG_BASE, i, OFF_TCFG)),
      .ticlr_we (csr.we && csr.waddr == chan_addr(TCFG_BASE, i, OFF_TICLR)),
      .tick     (tick),
      .wmask    (csr.wmask),
      .wdata    (csr.wdata),
      .tcfg     (tcfg[i]),
      .tval     (tval[i]),
      .pending  (timer_int[i])
    );
  end
  always_comb begin
    rdata = csr.raddr == PSC_ADDR ? 32'(psc_val) : '0;
    rhit  = csr.raddr == PSC_ADDR;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      rdata |= csr.raddr == chan_addr(TCFG_BASE, i, OFF_TCFG) ? tcfg[i] : '0;
      rdata |= csr.raddr == chan_addr(TCFG_BASE, i, OFF_TVAL) ? tval[i] : '0;
      rhit  |= csr.raddr == chan_addr(TCFG_BASE, i, OFF_TCFG) ||
               csr.raddr == chan_addr(TCFG_BASE, i, OFF_TVAL) ||
               csr.raddr == chan_addr(TCFG_BASE, i, OFF_TICLR);
    end
  end
  assign csr.rdata     = rdata;
  assign csr.rhit      = rhit;
  assign timer_int_any = |timer_int;
endmodule

// File: tb/tb_csr_timer_unit.sv
// tb_csr_timer_unit: scoreboard bench driving a 1x32-bit and a 4x16-bit timer unit against a reference model
module tb_csr_timer_unit;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [13:0] raddr = '0, waddr = '0;
  logic        we = 1'b0;
  logic [31:0] wmask = '0, wdata = '0;
  logic [0:0]  int_a;
  logic [3:0]  int_b;
  logic        any_a, any_b;
  logic [63:0] st_a, st_b;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  csr_timer_unit_if ifa ();
  csr_timer_unit_if ifb ();
  assign ifa.raddr = raddr;
  assign ifa.we    = we;
  assign ifa.waddr = waddr;
  assign ifa.wmask = wmask;
  assign ifa.wdata = wdata;
  assign ifb.raddr = raddr;
  assign ifb.we    = we;
  assign ifb.waddr = waddr;
  assign ifb.wmask = wmask;
  assign ifb.wdata = wdata;

  csr_timer_unit dut_a (
    .clk(clk), .resetn(resetn), .csr(ifa),
    .timer_int(int_a), .timer_int_any(any_a), .stable_cnt(st_a)
  );
  csr_timer_unit #(.NUM_TIMERS(4), .CNT_W(16)) dut_b (
    .clk(clk), .resetn(resetn), .csr(ifb),
    .timer_int(int_b), .timer_int_any(any_b), .stable_cnt(st_b)
  );

  typedef struct {
    logic [31:0] rd;
    logic        hit;
    logic [7:0]  ti;
    logic        any;
    logic [63:0] st;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  logic [31:0] m_cnt [2][8];
  logic [31:0] m_iv  [2][8];
  logic        m_en  [2][8];
  logic        m_per [2][8];
  logic        m_pend[2][8];
  logic [31:0] m_pv[2], m_pc[2];
  logic [63:0] m_st[2];

  function automatic int nt(input int d);
    return d == 0 ? 1 : 4;
  endfunction
  function automatic logic [31:0] ones(input int d);
    return d == 0 ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction
  function automatic logic [31:0] tcfg_of(input int d, input int c);
    return m_iv[d][c] * 4 + (m_per[d][c] ? 32'd2 : 32'd0) + (m_en[d][c] ? 32'd1 : 32'd0);
  endfunction
  function automatic logic [13:0] adr(input int c, input int off);
    return 14'h41 + 14'(4 * c + off);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 8; c++) begin
        m_cnt[d][c] = ones(d); m_iv[d][c] = 0; m_en[d][c] = 0; m_per[d][c] = 0; m_pend[d][c] = 0;
      end
      m_pv[d] = 0; m_pc[d] = 0; m_st[d] = 0;
    end
  endtask

  function automatic exp_t expect_of(input int d);
    exp_t e;
    e.rd = 0; e.hit = 0; e.ti = 0;
    for (int c = 0; c < nt(d); c++) begin
      if (raddr == adr(c, 0)) begin e.hit = 1; e.rd = tcfg_of(d, c); end
      if (raddr == adr(c, 1)) begin e.hit = 1; e.rd = m_cnt[d][c]; end
      if (raddr == adr(c, 3)) e.hit = 1;
      e.ti[c] = m_pend[d][c];
    end
    if (raddr == 14'h48) begin e.hit = 1; e.rd = e.rd | m_pv[d]; end
    e.any = |e.ti;
    e.st = m_st[d];
    return e;
  endfunction

  task automatic model_step(input int d);
    logic pw, tick, fired;
    logic [31:0] nv;
    pw = we && waddr == 14'h48;
    tick = m_pv[d] == m_pc[d] && !pw;
    for (int c = 0; c < nt(d); c++) begin
      fired = 0;
      if (we && waddr == adr(c, 0)) begin
        nv = ((wmask & wdata) | (~wmask & tcfg_of(d, c))) & ones(d);
        m_en[d][c] = nv[0]; m_per[d][c] = nv[1]; m_iv[d][c] = nv >> 2;
        if (nv[0]) m_cnt[d][c] = m_iv[d][c] * 4;
      end else if (m_en[d][c] && tick && m_cnt[d][c] != ones(d)) begin
        if (m_cnt[d][c] == 0) begin
          fired = 1;
          m_cnt[d][c] = m_per[d][c] ? m_iv[d][c] * 4 : ones(d);
        end else m_cnt[d][c] = m_cnt[d][c] - 1;
      end
      if (fired) m_pend[d][c] = 1;
      else if (we && waddr == adr(c, 3) && wmask[0] && wdata[0]) m_pend[d][c] = 0;
    end
    if (pw) begin
      m_pv[d] = ((wmask & wdata) | (~wmask & m_pv[d])) & 32'hFFFF;
      m_pc[d] = 0;
    end else m_pc[d] = tick ? 0 : m_pc[d] + 1;
    m_st[d] = m_st[d] + 1;
  endtask

  task automatic cycle(input logic r, input logic w, input logic [13:0] ra, input logic [13:0] wa,
                       input logic [31:0] m, input logic [31:0] dat);
    @(posedge clk);
    #1;
    resetn = r; raddr = ra; we = w; waddr = wa; wmask = m; wdata = dat;
    if (!r) model_reset();
    qa.push_back(expect_of(0));
    qb.push_back(expect_of(1));
    if (r) begin model_step(0); model_step(1); end
  endtask

  task automatic idle(input int n, input logic [13:0] ra);
    for (int i = 0; i < n; i++) cycle(1, 0, ra, 0, 0, 0);
  endtask
  task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] dat, input logic [13:0] ra);
    cycle(1, 1, ra, a, m, dat);
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_rdata", 64'(ifa.rdata), 64'(e.rd));
      chk("a_rhit", 64'(ifa.rhit), 64'(e.hit));
      chk("a_timer_int", 64'(int_a), 64'(e.ti[0]));
      chk("a_int_any", 64'(any_a), 64'(e.any));
      chk("a_stable", st_a, e.st);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_rdata", 64'(ifb.rdata), 64'(e.rd));
      chk("b_rhit", 64'(ifb.rhit), 64'(e.hit));
      chk("b_timer_int", 64'(int_b), 64'(e.ti[3:0]));
      chk("b_int_any", 64'(any_b), 64'(e.any));
      chk("b_stable", st_b, e.st);
    end
  end

  logic [13:0] pool [16] = '{14'h41, 14'h42, 14'h43, 14'h44, 14'h45, 14'h46, 14'h48, 14'h49,
                             14'h4A, 14'h4B, 14'h4C, 14'h4D, 14'h4F, 14'h50, 14'h00, 14'h3FFF};

  initial begin
    logic [13:0] a;
    logic [31:0] m, dat;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 14'h42, 0, 0, 0);
    idle(2, 14'h42);
    // one-shot count from 0x10 then idle, pending sticks
    wr(14'h41, 32'hFFFF_FFFF, 32'h11, 14'h42);
    idle(24, 14'h42);
    idle(2, 14'h41);
    // reset dropped mid-count, then stable counter restarts from zero
    wr(14'h41, 32'hFFFF_FFFF, 32'h11, 14'h42);
    idle(3, 14'h42);
    cycle(0, 0, 14'h42, 0, 0, 0);
    cycle(0, 0, 14'h41, 0, 0, 0);
    idle(6, 14'h42);
    // periodic with clears, including clears landing on the reload tick
    wr(14'h41, 32'hFFFF_FFFF, 32'h0B, 14'h42);
    idle(20, 14'h42);
    wr(14'h44, 32'hFFFF_FFFF, 32'h1, 14'h42);
    for (int i = 0; i < 12; i++) wr(14'h44, 32'h1, 32'h1, 14'h42);
    idle(5, 14'h44);
    // prescaler by 4, then restart its phase mid-run
    wr(14'h48, 32'hFFFF_FFFF, 32'h3, 14'h48);
    wr(14'h41, 32'hFFFF_FFFF, 32'h05, 14'h42);
    idle(22, 14'h42);
    wr(14'h41, 32'hFFFF_FFFF, 32'h05, 14'h42);
    idle(6, 14'h42);
    wr(14'h48, 32'hFFFF_FFFF, 32'h3, 14'h42);
    idle(12, 14'h42);
    wr(14'h48, 32'hFFFF_FFFF, 32'h0, 14'h48);
    wr(14'h41, 32'hFFFF_FFFF, 32'h0, 14'h41);
    // channel 2 only exists in the 4-channel instance
    wr(14'h49, 32'hFFFF_FFFF, 32'hFFFF_0011, 14'h49);
    idle(20, 14'h4A);
    idle(2, 14'h4B);
    idle(2, 14'h49);
    // masked enable reuses the preset INITV, TVAL writes are ignored
    wr(14'h41, 32'hFFFF_FFFF, 32'h1C, 14'h41);
    wr(14'h41, 32'h1, 32'h1, 14'h42);
    wr(14'h42, 32'hFFFF_FFFF, 32'h5, 14'h42);
    wr(14'h4A, 32'hFFFF_FFFF, 32'h5, 14'h4A);
    idle(4, 14'h42);
    // periodic with INITV=0 fires every tick
    wr(14'h41, 32'hFFFF_FFFF, 32'h3, 14'h42);
    wr(14'h44, 32'h1, 32'h1, 14'h42);
    idle(3, 14'h42);
    for (int i = 0; i < 3000; i++) begin
      a = pool[$urandom_range(0, 15)];
      case ($urandom_range(0, 2))
        0: m = 32'hFFFF_FFFF;
        1: m = 32'h1;
        default: m = $urandom;
      endcase
      dat = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
      if (a == 14'h48) dat = dat & 32'h3;
      if ($urandom_range(0, 499) == 0) cycle(0, 0, pool[$urandom_range(0, 15)], 0, 0, 0);
      else if ($urandom_range(0, 3) == 0) cycle(1, 1, pool[$urandom_range(0, 15)], a, m, dat);
      else cycle(1, 0, pool[$urandom_range(0, 15)], 0, 0, 0);
    end
    idle(1, 14'h0);
    @(negedge clk);
    #1;
    if (qa.size() != 0 || qb.size() != 0) chk("queue_drain", 64'(qa.size() + qb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
